// File: rtl/bf16_result_packer.sv
// Rounds FP32 MAC results to bfloat16 and packs PACK lanes per output word (lane 0 at [15:0]).
// Optional macro BF16_PACK_SAT_EN: rounding overflow of a finite input saturates to max finite.
module bf16_result_packer #(
    parameter int unsigned PACK   = 2,
    parameter int unsigned CWIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          rnd,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CWIDTH-1:0]   in_data,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [16*PACK-1:0]  out_data,
    output logic [PACK-1:0]     out_keep,
    output logic                out_last
);
    localparam int unsigned   CW       = (PACK > 1) ? $clog2(PACK) : 1;
    localparam logic [CW-1:0] LastLane = CW'(PACK - 1);

    logic              w_sign;
    logic [7:0]        w_exp;
    logic              w_mant_nz;
    logic [15:0]       w_hi;
    logic              w_g;
    logic              w_s;
    logic              w_l;
    logic              w_inc;
    logic [15:0]       w_sum;
    logic [15:0]       w_rounded;

    logic              r_s1_valid;
    logic [15:0]       r_s1_data;
    logic              r_s1_last;
    logic [CW-1:0]     r_lane_cnt;
    logic [16*PACK-1:0] r_lane_buf;
    logic [PACK-1:0]   r_keep_buf;
    logic              r_out_valid;
    logic [16*PACK-1:0] r_out_data;
    logic [PACK-1:0]   r_out_keep;
    logic              r_out_last;

    logic              w_adv;
    logic              w_accept;
    logic              w_s2_fire;
    logic              w_complete;
    logic [16*PACK-1:0] w_word_data;
    logic [PACK-1:0]   w_word_keep;

    always_comb begin
        w_sign    = in_data[31];
        w_exp     = in_data[30:23];
        w_mant_nz = |in_data[22:0];
        w_hi      = in_data[31:16];
        w_g       = in_data[15];
        w_s       = |in_data[14:0];
        w_l       = in_data[16];
        case (rnd)
            2'b01:   w_inc = w_g;
            2'b10:   w_inc = w_g & (w_s | w_l);
            default: w_inc = 1'b0;
        endcase
        // Mantissa carry ripples into the exponent; FE/all-ones + 1 lands on Inf.
        w_sum = w_hi + {15'h0, w_inc};
        if (w_exp == 8'hFF) begin
            w_rounded = w_mant_nz ? 16'h7FC0 : w_hi;
        end else if (w_exp == 8'h00) begin
            w_rounded = {w_sign, 15'h0};
        end else begin
            w_rounded = w_sum;
`ifdef BF16_PACK_SAT_EN
            if (w_sum[14:7] == 8'hFF) begin
                w_rounded = {w_sign, 15'h7F7F};
            end
`endif
        end
    end

    assign w_adv      = ~r_out_valid | out_ready;
    assign in_ready   = ~r_s1_valid | w_adv;
    assign w_accept   = in_valid & in_ready;
    assign w_s2_fire  = r_s1_valid & w_adv;
    assign w_complete = (r_lane_cnt == LastLane) | r_s1_last;

    always_comb begin
        w_word_data = r_lane_buf;
        w_word_keep = r_keep_buf;
        for (int i = 0; i < int'(PACK); i++) begin
            if (r_lane_cnt == CW'(i)) begin
                w_word_data[16*i +: 16] = r_s1_data;
                w_word_keep[i]          = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= 16'h0;
            r_s1_last  <= 1'b0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_data  <= w_rounded;
            r_s1_last  <= in_last;
        end else if (w_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lane_cnt  <= '0;
            r_lane_buf  <= '0;
            r_keep_buf  <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_keep  <= '0;
            r_out_last  <= 1'b0;
        end else begin
            // A completing word may replace the one being handed off in the same cycle.
            if (w_adv) begin
                r_out_valid <= w_s2_fire & w_complete;
            end
            if (w_s2_fire) begin
                if (w_complete) begin
                    r_out_data <= w_word_data;
                    r_out_keep <= w_word_keep;
                    r_out_last <= r_s1_last;
                    r_lane_buf <= '0;
                    r_keep_buf <= '0;
                    r_lane_cnt <= '0;
                end else begin
                    r_lane_buf <= w_word_data;
                    r_keep_buf <= w_word_keep;
                    r_lane_cnt <= r_lane_cnt + CW'(1);
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_keep  = r_out_keep;
    assign out_last  = r_out_last;

endmodule

// File: tb/tb_bf16_result_packer.sv
// Self-checking bench for bf16_result_packer (PACK=2): rounding, packing, backpressure, reset.
module tb_bf16_result_packer;
    localparam int unsigned PACK = 2;
`ifdef BF16_PACK_SAT_EN
    localparam logic [15:0] OvfPos = 16'h7F7F;
    localparam logic [15:0] OvfNeg = 16'hFF7F;
`else
    localparam logic [15:0] OvfPos = 16'h7F80;
    localparam logic [15:0] OvfNeg = 16'hFF80;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  rnd = 2'b00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = 32'h0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [1:0]  out_keep;
    logic        out_last;

    int checks = 0;
    int failures = 0;

    logic [34:0] exp_q[$];  // {data, keep, last}
    logic [34:0] mon_e;
    logic [31:0] m_buf = 32'h0;
    logic [1:0]  m_keep = 2'b00;
    int          m_cnt = 0;

    bf16_result_packer #(.PACK(PACK), .CWIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .rnd       (rnd),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    // Scoreboard: every word handed off at the next posedge is checked in order.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_word got=%h exp=none", {out_data, out_keep, out_last});
            end
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                checks++;
                assert ({out_data, out_keep, out_last} === mon_e) else begin
                    failures++;
                    $error("FAIL word got=%h exp=%h", {out_data, out_keep, out_last}, mon_e);
                end
            end
        end
    end

    task automatic send(input logic [31:0] d, input logic [1:0] m, input logic l,
                        input logic [15:0] lane);
        int   n;
        logic hs;
        n  = 0;
        hs = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        rnd      = m;
        in_last  = l;
        while (!hs && n < 100) begin
            @(negedge clk);
            hs = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++;
        assert (hs === 1'b1) else begin
            failures++;
            $error("FAIL send_timeout data=%h got_ready=%b exp_ready=1", d, hs);
        end
        if (hs) begin
            m_buf[16*m_cnt +: 16] = lane;
            m_keep[m_cnt] = 1'b1;
            if (m_cnt == int'(PACK) - 1 || l) begin
                exp_q.push_back({m_buf, m_keep, l});
                m_buf  = 32'h0;
                m_keep = 2'b00;
                m_cnt  = 0;
            end else begin
                m_cnt++;
            end
        end
    endtask

    initial begin
        #1;
        checks++;
        assert ({out_valid, out_data, out_keep, out_last} === 36'h0) else begin
            failures++;
            $error("FAIL reset_outputs got=%h exp=0", {out_valid, out_data, out_keep, out_last});
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        assert (in_ready === 1'b1) else begin
            failures++;
            $error("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
        @(posedge clk);
        #1;

        // Rounding: each value is its own flushed word.
        send(32'h3F808000, 2'b10, 1'b1, 16'h3F80);
        send(32'h3F808000, 2'b01, 1'b1, 16'h3F81);
        send(32'h3F808000, 2'b00, 1'b1, 16'h3F80);
        send(32'h3F80FFFF, 2'b11, 1'b1, 16'h3F80);
        send(32'h3F818000, 2'b10, 1'b1, 16'h3F82);
        send(32'h7FC00001, 2'b10, 1'b1, 16'h7FC0);
        send(32'hFFC00000, 2'b01, 1'b1, 16'h7FC0);
        send(32'h00000001, 2'b10, 1'b1, 16'h0000);
        send(32'h80400000, 2'b10, 1'b1, 16'h8000);
        send(32'hFF800000, 2'b01, 1'b1, 16'hFF80);
        send(32'h7F7FFFFF, 2'b01, 1'b1, OvfPos);
        send(32'hFF7FFFFF, 2'b10, 1'b1, OvfNeg);

        // Packing: full word then a flushed partial word.
        send(32'h40000000, 2'b10, 1'b0, 16'h4000);
        send(32'h3F800000, 2'b10, 1'b0, 16'h3F80);
        send(32'h40400000, 2'b10, 1'b1, 16'h4040);
        repeat (4) @(posedge clk);
        #1;

        // Backpressure: six values while out_ready is low for five cycles.
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    send({16'h4100 + 16'(i), 16'h0}, 2'b10, 1'b0, 16'h4100 + 16'(i));
                end
            end
            begin
                repeat (4) @(negedge clk);
                checks++;
                assert (out_valid === 1'b1 && out_data === 32'h41014100) else begin
                    failures++;
                    $error("FAIL stall_word got=%b/%h exp=1/41014100", out_valid, out_data);
                end
                @(negedge clk);
                checks++;
                assert (out_data === 32'h41014100) else begin
                    failures++;
                    $error("FAIL stall_stable got=%h exp=41014100", out_data);
                end
                checks++;
                assert (in_ready === 1'b0) else begin
                    failures++;
                    $error("FAIL stall_in_ready got=%b exp=0", in_ready);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        repeat (6) @(posedge clk);
        #1;

        // Reset with one lane buffered: partial lane must vanish.
        send(32'h40A00000, 2'b10, 1'b0, 16'h40A0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        m_buf  = 32'h0;
        m_keep = 2'b00;
        m_cnt  = 0;
        #1;
        checks++;
        assert ({out_valid, out_data, out_keep, out_last} === 36'h0) else begin
            failures++;
            $error("FAIL midreset_outputs got=%h exp=0", {out_valid, out_data, out_keep, out_last});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        send(32'h40400000, 2'b10, 1'b0, 16'h4040);
        send(32'h3F800000, 2'b10, 1'b0, 16'h3F80);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        checks++;
        assert (exp_q.size() === 0) else begin
            failures++;
            $error("FAIL drain got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bf16_result_packer.md
Name: bf16_result_packer

Overview:
Drain-side companion to the bfloat16 FMA datapath. It accepts FP32 accumulator results from the MAC on a valid/ready stream and rounds each to bfloat16 using the MAC's rounding-mode encoding. It packs PACK consecutive bf16 values into one output word for the writeback/memory interface. The MAC consumes bf16 and emits FP32; this block closes the loop back to bf16 storage.

Parameters:
PACK, 2, bf16 lanes per output word (1..4)
CWIDTH, 32, input result width (FP32)

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
rnd  input  2  rounding mode: 00 RTZ, 01 round-nearest ties-away, 10 RNE, 11 treated as RTZ
in_valid  input  1  input result valid
in_ready  output  1  block can accept input
in_data  input  CWIDTH  FP32 result from MAC
in_last  input  1  final result of a tile; forces partial-word flush
out_valid  output  1  packed word valid
out_ready  input  1  downstream accepts word
out_data  output  16*PACK  packed bf16 lanes, lane 0 = first result, at bits [15:0]
out_keep  output  PACK  per-lane valid mask
out_last  output  1  word contains the in_last result

Behaviour:
- Reset (async, rst=1): s1_valid=0, lane_cnt=0, lane buffer=0, out_valid=0, out_data=0, out_keep=0, out_last=0; in_ready=1 the cycle after rst deasserts. Reset mid-word discards partial lanes, with no flush.
- Stage 1 (round register): captures the rounded bf16 value plus last flag on in_valid & in_ready. rnd is sampled together with the data.
- Rounding: hi=in_data[31:16], G=bit15, S=|bits14:0, L=bit16.
  - RTZ: hi.
  - RN: hi+G.
  - RNE: hi+(G&(S|L)).
  - Mantissa carry into the exponent is natural. Exponent 0xFE with all-ones mantissa plus a round-up gives 0x7F80/0xFF80 (Inf).
- Specials:
  - NaN (exp=FF, mant!=0) -> 16'h7FC0, sign discarded.
  - Inf passes unchanged.
  - FP32 subnormal (exp=0) -> signed zero {sign,15'h0}, no rounding.
- Stage 2 (packer): when s1_valid and stage-2 advance, write lane lane_cnt and set keep[lane_cnt].
  - Word completes when lane_cnt==PACK-1 or the s1 last flag is set.
  - On completion: out_data/out_keep/out_last are loaded, out_valid=1 next cycle, and lane_cnt resets to 0.
  - Otherwise lane_cnt increments.
  - Unfilled lanes of a flushed word are 0 with keep bit 0.
- Stage-2 advance = ~out_valid | out_ready. in_ready = ~s1_valid | advance.
- Full throughput: one result per cycle with out_ready held high.
- Min latency PACK=1: accepted in cycle 0, out_valid high in cycle 2.
- Output register holds stable while out_valid & ~out_ready.
- Simultaneous events:
  - Output handshake and new word completion in the same cycle: the new word replaces the old, out_valid stays 1.
  - Handshake with no completion: out_valid drops to 0.
- PACK=1: every result is its own word; out_keep=1.

Optional Feature:
BF16_PACK_SAT_EN: when defined, any rounding that produces Inf from a finite input yields max finite 0x7F7F/0xFF7F. Inputs that are already Inf and NaN handling are unchanged. When undefined, overflow rounds to Inf as specified above.

Test Plan:
- rnd=10, in_data 0x3F808000 -> lane 0x3F80; rnd=01 same input -> 0x3F81; rnd=00 -> 0x3F80.
- rnd=10, 0x3F818000 -> 0x3F82 (tie, odd LSB rounds up); 0x7FC00001 -> 0x7FC0; 0x00000001 -> 0x0000; 0x80400000 -> 0x8000.
- rnd=01, 0x7F7FFFFF -> 0x7F80; with BF16_PACK_SAT_EN -> 0x7F7F.
- PACK=2, out_ready=1:
  - Inputs 0x40000000 then 0x3F800000 -> out_data 0x3F804000, out_keep 2'b11, out_last 0.
  - Single input 0x40400000 with in_last=1 -> out_data 0x00004040, keep 2'b01, out_last 1.
- Backpressure: stream 6 values with out_ready low for 5 cycles -> in_ready drops after the pipeline fills, no value lost or duplicated, out_data stable while stalled, 3 words emitted in order.
- Assert rst after one lane of a PACK=2 word is buffered -> outputs zero immediately. Next two inputs form a fresh word with no stale lane.
